uart_rx: RTL and testbench

UART receiver feeding the RX byte FIFO: it oversamples the asynchronous `rx` pin on the system clock and recovers 8N1 frames. For each good frame it presents the byte with a one-cycle `write_trig` strobe that drives the FIFO write port directly. Frames with a bad stop bit are flagged and dropped.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver. It oversamples the rx pin on the system clock and delivers each
// good byte with a one-cycle write_trig strobe; a frame with a bad stop bit raises frame_err.
module uart_rx #(
  parameter int BIT_CLKS = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       write_trig,
  output logic       frame_err,
  output logic       busy
);

  localparam int              CW      = $clog2(BIT_CLKS);
  localparam logic [CW-1:0]   HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0]   BIT_M1  = CW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_zero;
  logic          load_half, load_bit, dec, shift, trig_set, err_set;

  assign cnt_zero = (cnt == '0);

  // NOTE: both synchronizer flops reset to the idle level so that reset cannot fake a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each combinational process assigns every output first so that no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (!rxs) state_nxt = S_START;
      S_START: if (cnt_zero) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_zero && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (cnt_zero) state_nxt = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_bit  = 1'b0;
    dec       = 1'b0;
    shift     = 1'b0;
    trig_set  = 1'b0;
    err_set   = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE:  load_half = ~rxs;
      S_START: begin
        if (cnt_zero) load_bit = ~rxs;
        else          dec      = 1'b1;
      end
      S_DATA: begin
        if (cnt_zero) begin
          shift    = 1'b1;
          load_bit = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_zero) begin
          trig_set = rxs;
          err_set  = ~rxs;
        end else begin
          dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Strobes are registered and fall back to zero on every cycle they are not requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      write_trig <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      write_trig <= trig_set;
      frame_err  <= err_set;
      if (load_half)     cnt <= HALF_M1;
      else if (load_bit) cnt <= BIT_M1;
      else if (dec)      cnt <= cnt - 1'b1;
      if (load_half)  bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 1'b1;
      if (shift)    shreg <= {rxs, shreg[7:1]};
      if (trig_set) data  <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames and corner sequences at BIT_CLKS=16, plus
// randomized bytes at +/-4% transmitter rate error on two BIT_CLKS=104 instances.
module tb_uart_rx;

  localparam int BC16  = 16;
  localparam int BC104 = 104;
  localparam int NBAUD = 40;

  logic       clk = 1'b0;
  logic       reset16, reset104;
  logic       rx16, rx_f, rx_s;
  logic [7:0] d16, d_f, d_s;
  logic       wt16, wt_f, wt_s, fe16, fe_f, fe_s, busy16, busy_f, busy_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx #(.BIT_CLKS(BC16)) dut16 (
    .clk(clk), .reset(reset16), .rx(rx16), .data(d16),
    .write_trig(wt16), .frame_err(fe16), .busy(busy16)
  );
  uart_rx #(.BIT_CLKS(BC104)) dut_fast (
    .clk(clk), .reset(reset104), .rx(rx_f), .data(d_f),
    .write_trig(wt_f), .frame_err(fe_f), .busy(busy_f)
  );
  uart_rx #(.BIT_CLKS(BC104)) dut_slow (
    .clk(clk), .reset(reset104), .rx(rx_s), .data(d_s),
    .write_trig(wt_s), .frame_err(fe_s), .busy(busy_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [7:0] b, input logic stop);
    rx16 = 1'b0;
    wait_clks(BC16);
    for (int i = 0; i < 8; i++) begin
      rx16 = b[i];
      wait_clks(BC16);
    end
    rx16 = stop;
    wait_clks(BC16);
    rx16 = 1'b1;
  endtask

  task automatic drive_baud(input bit slow, input logic v);
    if (slow) rx_s = v;
    else      rx_f = v;
  endtask

  task automatic send_baud(input bit slow, input logic [7:0] b, input int bl);
    drive_baud(slow, 1'b0);
    wait_clks(bl);
    for (int i = 0; i < 8; i++) begin
      drive_baud(slow, b[i]);
      wait_clks(bl);
    end
    drive_baud(slow, 1'b1);
    wait_clks(bl);
  endtask

  // Monitor for the BIT_CLKS=16 instance.
  int unsigned cyc = 0;
  int          trig_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  logic [7:0]  trig_data_q[$];
  int unsigned trig_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wt16) begin
      trig_cnt++;
      trig_data_q.push_back(d16);
      trig_cyc_q.push_back(cyc);
    end
    if (fe16) err_cnt++;
    if (wt16 && fe16) overlap_cnt++;
  end

  // Reference model for the baud-tolerance runs: expected bytes in send order.
  logic [7:0] q_f[$], q_s[$];
  int         got_f = 0, got_s = 0, err_f = 0, err_s = 0;

  always @(negedge clk) begin
    if (wt_f) begin
      got_f++;
      check("baud_fast_data", {24'd0, d_f}, (q_f.size() > 0) ? {24'd0, q_f.pop_front()} : 32'hdead_beef);
    end
    if (wt_s) begin
      got_s++;
      check("baud_slow_data", {24'd0, d_s}, (q_s.size() > 0) ? {24'd0, q_s.pop_front()} : 32'hdead_beef);
    end
    if (fe_f) err_f++;
    if (fe_s) err_s++;
  end

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_trig;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          bt, be, spur;
    int unsigned t_fall;

    tbl[0] = '{8'hA3, 1'b0, 0, 1, 8'h55};
    tbl[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    tbl[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
    tbl[4] = '{8'h5A, 1'b0, 0, 1, 8'h81};
    tbl[5] = '{8'hE7, 1'b1, 1, 0, 8'hE7};

    reset16 = 1'b1; reset104 = 1'b1;
    rx16 = 1'b1; rx_f = 1'b1; rx_s = 1'b1;
    #2;
    check("reset_data", {24'd0, d16}, 32'h00);
    check("reset_write_trig", {31'd0, wt16}, 32'd0);
    check("reset_frame_err", {31'd0, fe16}, 32'd0);
    check("reset_busy", {31'd0, busy16}, 32'd0);
    wait_clks(3);
    reset16 = 1'b0; reset104 = 1'b0;
    wait_clks(2);

    fork
      begin : seq16
        // Single frame with exact strobe timing.
        trig_data_q.delete(); trig_cyc_q.delete();
        bt = trig_cnt; be = err_cnt; t_fall = cyc;
        send16(8'h55, 1'b1);
        wait_clks(3 * BC16);
        check("t1_trig_count", trig_cnt - bt, 1);
        check("t1_data", {24'd0, d16}, 32'h55);
        check("t1_trig_cycle", (trig_cyc_q.size() > 0) ? trig_cyc_q[0] - t_fall : 0,
              3 + BC16 / 2 + 9 * BC16);
        check("t1_busy_after", {31'd0, busy16}, 0);
        check("t1_err_count", err_cnt - be, 0);

        for (int i = 0; i < 6; i++) begin
          bt = trig_cnt; be = err_cnt;
          send16(tbl[i].tx, tbl[i].stop);
          wait_clks(3 * BC16);
          check($sformatf("vec%0d_trig", i), trig_cnt - bt, tbl[i].exp_trig);
          check($sformatf("vec%0d_err", i), err_cnt - be, tbl[i].exp_err);
          check($sformatf("vec%0d_data", i), {24'd0, d16}, {24'd0, tbl[i].exp_data});
          check($sformatf("vec%0d_busy", i), {31'd0, busy16}, 0);
        end

        // Glitch: line low for 5 clocks only.
        bt = trig_cnt; be = err_cnt;
        rx16 = 1'b0;
        wait_clks(4);
        check("glitch_busy_high", {31'd0, busy16}, 1);
        wait_clks(1);
        rx16 = 1'b1;
        wait_clks(7);
        check("glitch_busy_low", {31'd0, busy16}, 0);
        wait_clks(2 * BC16);
        check("glitch_trig", trig_cnt - bt, 0);
        check("glitch_err", err_cnt - be, 0);
        check("glitch_data", {24'd0, d16}, 32'hE7);

        // Bad stop bit followed by a long break.
        bt = trig_cnt; be = err_cnt;
        rx16 = 1'b0;
        wait_clks(BC16);
        for (int i = 0; i < 8; i++) begin
          rx16 = tbl[0].tx[i];
          wait_clks(BC16);
        end
        rx16 = 1'b0;
        wait_clks(40 * BC16);
        check("break_busy_held", {31'd0, busy16}, 1);
        check("break_err_once", err_cnt - be, 1);
        rx16 = 1'b1;
        wait_clks(1);
        check("break_busy_sync", {31'd0, busy16}, 1);
        wait_clks(3);
        check("break_busy_release", {31'd0, busy16}, 0);
        wait_clks(2 * BC16);
        check("break_err_total", err_cnt - be, 1);
        check("break_trig", trig_cnt - bt, 0);
        check("break_data", {24'd0, d16}, 32'hE7);

        // Back-to-back frames with zero idle gap.
        trig_data_q.delete(); trig_cyc_q.delete();
        bt = trig_cnt;
        send16(8'h00, 1'b1);
        send16(8'hFF, 1'b1);
        send16(8'h81, 1'b1);
        wait_clks(3 * BC16);
        check("b2b_count", trig_cnt - bt, 3);
        if (trig_data_q.size() == 3) begin
          check("b2b_byte0", {24'd0, trig_data_q[0]}, 32'h00);
          check("b2b_byte1", {24'd0, trig_data_q[1]}, 32'hFF);
          check("b2b_byte2", {24'd0, trig_data_q[2]}, 32'h81);
          for (int i = 1; i < 3; i++) begin
            int gap;
            gap = int'(trig_cyc_q[i] - trig_cyc_q[i-1]);
            check($sformatf("b2b_gap%0d", i), gap, (gap >= 10 * BC16 - 1 && gap <= 10 * BC16 + 1) ? gap : 10 * BC16);
          end
        end

        // Reset during data bit 4 of 0x3C, then a clean 0xC3.
        bt = trig_cnt; be = err_cnt;
        rx16 = 1'b0;
        wait_clks(BC16);
        for (int i = 0; i < 4; i++) begin
          rx16 = 8'h3C >> i;
          wait_clks(BC16);
        end
        rx16 = 1'b1;
        wait_clks(BC16 / 2);
        check("rst_pre_busy", {31'd0, busy16}, 1);
        reset16 = 1'b1;
        #1;
        check("rst_async_data", {24'd0, d16}, 0);
        check("rst_async_busy", {31'd0, busy16}, 0);
        check("rst_async_trig", {31'd0, wt16}, 0);
        check("rst_async_err", {31'd0, fe16}, 0);
        wait_clks(2);
        reset16 = 1'b0;
        wait_clks(BC16 / 2);
        for (int i = 5; i < 8; i++) begin
          rx16 = 8'h3C >> i;
          wait_clks(BC16);
        end
        rx16 = 1'b1;
        wait_clks(12 * BC16);
        spur = (trig_cnt - bt) + (err_cnt - be);
        check("rst_spurious_le1", spur, (spur <= 1) ? spur : 1);
        trig_data_q.delete();
        bt = trig_cnt; be = err_cnt;
        send16(8'hC3, 1'b1);
        wait_clks(3 * BC16);
        check("rst_clean_count", trig_cnt - bt, 1);
        check("rst_clean_data", {24'd0, d16}, 32'hC3);
        check("rst_clean_err", err_cnt - be, 0);
        check("overlap_never", overlap_cnt, 0);
      end
      begin : fast_tx
        for (int k = 0; k < NBAUD; k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          q_f.push_back(b);
          send_baud(1'b0, b, 100);
          wait_clks($urandom_range(30, 0));
        end
      end
      begin : slow_tx
        for (int k = 0; k < NBAUD; k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          q_s.push_back(b);
          send_baud(1'b1, b, 108);
          wait_clks($urandom_range(30, 0));
        end
      end
    join

    wait_clks(3 * BC104);
    check("baud_fast_count", got_f, NBAUD);
    check("baud_slow_count", got_s, NBAUD);
    check("baud_fast_frame_err", err_f, 0);
    check("baud_slow_frame_err", err_s, 0);
    check("baud_fast_busy", {31'd0, busy_f}, 0);
    check("baud_slow_busy", {31'd0, busy_s}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
